// File: rtl/upsample_pkg.sv
// Shared defaults and state encodings for the output line buffer.
package upsample_pkg;

    localparam int unsigned DefPixelWidth  = 24;
    localparam int unsigned DefInLineWidth = 960;

    // Per-bank occupancy state.
    typedef enum logic [1:0] {
        BankFree     = 2'd0,
        BankFilling  = 2'd1,
        BankFull     = 2'd2,
        BankDraining = 2'd3
    } bank_state_e;

    // Read-issue FSM state.
    typedef enum logic [1:0] {
        RdIdle = 2'd0,
        RdTop  = 2'd1,
        RdBot  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/out_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
// The read register only updates on rd_en_i, so the last read word is held
// while the consumer is stalled.
module out_bank_ram
    import upsample_pkg::*;
#(
    parameter int unsigned Width = 4 * DefPixelWidth,
    parameter int unsigned Depth = DefInLineWidth
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(Depth)-1:0] wr_addr_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(Depth)-1:0] rd_addr_i,
    output logic [Width-1:0]         rd_data_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port, holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/out_line_buffer.sv
// Ping-pong output line buffer: stores one line of 2x2 groups per bank and
// emits it as a top row followed by a bottom row of 2-pixel beats.
// Optional interrupt pulse is built only when OUT_LINE_BUFFER_INTR_EN is
// defined; otherwise o_intr is tied low.
// The read FSM only issues RAM reads; a bank is released when its final beat
// is handshaken at the output, which lets the next bank be prefetched without
// a bubble. IN_LINE_WIDTH must be at least 2.
module out_line_buffer
    import upsample_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH   = DefPixelWidth,
    parameter int unsigned IN_LINE_WIDTH = DefInLineWidth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4*PIXEL_WIDTH-1:0] i_pixel_data,
    input  logic                     i_pixel_data_valid,
    output logic                     o_empty,
    output logic [2*PIXEL_WIDTH-1:0] o_pixel_data,
    output logic                     o_pixel_data_valid,
    input  logic                     i_ready,
    output logic                     o_last,
    output logic                     o_intr
);

    localparam int unsigned GroupW = 4 * PIXEL_WIDTH;
    localparam int unsigned BeatW  = 2 * PIXEL_WIDTH;
    localparam int unsigned CntW   = $clog2(IN_LINE_WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(IN_LINE_WIDTH - 1);

    bank_state_e     bank_q [2];
    bank_state_e     bank_d [2];

    logic            wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    logic            wr_fire, wr_wrap;

    rd_state_e       rd_state_q, rd_state_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
    logic            rd_issue, start_drain, drain_bank;

    // Stage 1: RAM read register contents and their tags.
    logic            s1_valid_q, s1_bank_q, s1_bot_q, s1_last_q;
    // Stage 2: output register.
    logic            out_valid_q, out_last_q, out_bot_q, out_bank_q;
    logic [BeatW-1:0] out_data_q;

    logic            handshake, out_load, release_line;
    logic            empty_q;
    logic [GroupW-1:0] ram_rd_data [2];
    logic [GroupW-1:0] s1_group;
    logic [BeatW-1:0]  s1_beat;

    // Write side: accept only into a free/filling bank, wrap at end of line.
    always_comb begin
        wr_fire  = i_pixel_data_valid &&
                   (bank_q[wr_ptr_q] == BankFree || bank_q[wr_ptr_q] == BankFilling);
        wr_wrap  = wr_fire && (wr_cnt_q == CntLast);
        wr_cnt_d = wr_cnt_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_fire) begin
            wr_cnt_d = wr_wrap ? '0 : wr_cnt_q + 1'b1;
        end
        if (wr_wrap) begin
            wr_ptr_d = ~wr_ptr_q;
        end
    end

    // Pipeline handshakes: issue a read whenever stage 1 is or becomes free.
    always_comb begin
        handshake    = out_valid_q && i_ready;
        out_load     = s1_valid_q && (!out_valid_q || i_ready);
        rd_issue     = (rd_state_q != RdIdle) && (!s1_valid_q || out_load);
        release_line = handshake && out_bot_q && out_last_q;
    end

    // Read FSM next state; chains straight into the other bank when it is full.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        start_drain = 1'b0;
        drain_bank  = rd_ptr_q;
        case (rd_state_q)
            RdIdle: begin
                if (bank_q[rd_ptr_q] == BankFull) begin
                    rd_state_d  = RdTop;
                    rd_cnt_d    = '0;
                    start_drain = 1'b1;
                end
            end
            RdTop: begin
                if (rd_issue) begin
                    if (rd_cnt_q == CntLast) begin
                        rd_cnt_d   = '0;
                        rd_state_d = RdBot;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            RdBot: begin
                if (rd_issue) begin
                    if (rd_cnt_q == CntLast) begin
                        rd_cnt_d   = '0;
                        rd_ptr_d   = ~rd_ptr_q;
                        drain_bank = ~rd_ptr_q;
                        if (bank_q[~rd_ptr_q] == BankFull) begin
                            rd_state_d  = RdTop;
                            start_drain = 1'b1;
                        end else begin
                            rd_state_d = RdIdle;
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    // Bank state next: write and read sides act on disjoint states.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (wr_fire && (wr_ptr_q == b[0])) begin
                bank_d[b] = wr_wrap ? BankFull : BankFilling;
            end
            if (start_drain && (drain_bank == b[0])) begin
                bank_d[b] = BankDraining;
            end
            if (release_line && (out_bank_q == b[0])) begin
                bank_d[b] = BankFree;
            end
        end
    end

    // Bank states, pointers, counters and FSM register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0]  <= BankFree;
            bank_q[1]  <= BankFree;
            wr_ptr_q   <= 1'b0;
            wr_cnt_q   <= '0;
            rd_state_q <= RdIdle;
            rd_ptr_q   <= 1'b0;
            rd_cnt_q   <= '0;
            empty_q    <= 1'b1;
        end else begin
            bank_q     <= bank_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_state_q <= rd_state_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            empty_q    <= (bank_d[wr_ptr_d] == BankFree);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        out_bank_ram #(
            .Width (GroupW),
            .Depth (IN_LINE_WIDTH)
        ) u_ram (
            .clk       (clk),
            .wr_en_i   (wr_fire && (wr_ptr_q == 1'(b))),
            .wr_addr_i (wr_cnt_q),
            .wr_data_i (i_pixel_data),
            .rd_en_i   (rd_issue && (rd_ptr_q == 1'(b))),
            .rd_addr_i (rd_cnt_q),
            .rd_data_o (ram_rd_data[b])
        );
    end

    // Pick the top or bottom pixel pair from the group in stage 1.
    always_comb begin
        s1_group = ram_rd_data[s1_bank_q];
        s1_beat  = s1_bot_q ? s1_group[GroupW-1:BeatW] : s1_group[BeatW-1:0];
    end

    // Stage 1 tags and output register; both hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_bank_q   <= 1'b0;
            s1_bot_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_bot_q   <= 1'b0;
            out_bank_q  <= 1'b0;
        end else begin
            if (rd_issue) begin
                s1_valid_q <= 1'b1;
                s1_bank_q  <= rd_ptr_q;
                s1_bot_q   <= (rd_state_q == RdBot);
                s1_last_q  <= (rd_cnt_q == CntLast);
            end else if (out_load) begin
                s1_valid_q <= 1'b0;
            end
            if (out_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= s1_beat;
                out_last_q  <= s1_last_q;
                out_bot_q   <= s1_bot_q;
                out_bank_q  <= s1_bank_q;
            end else if (handshake) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign o_empty            = empty_q;
    assign o_pixel_data       = out_data_q;
    assign o_pixel_data_valid = out_valid_q;
    assign o_last             = out_last_q;

`ifdef OUT_LINE_BUFFER_INTR_EN
    logic intr_q;

    // One-cycle pulse after the final bottom-row beat of a line transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= release_line;
        end
    end

    assign o_intr = intr_q;
`else
    assign o_intr = 1'b0;
`endif

endmodule

// File: tb/tb_out_line_buffer.sv
// Scoreboard bench for out_line_buffer with IN_LINE_WIDTH=4, PIXEL_WIDTH=24.
`timescale 1ns/1ps
module tb_out_line_buffer;

    localparam int PW = 24;
    localparam int W  = 4;
`ifdef OUT_LINE_BUFFER_INTR_EN
    localparam int IntrEn = 1;
`else
    localparam int IntrEn = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [4*PW-1:0] i_pixel_data;
    logic            i_pixel_data_valid;
    logic            o_empty;
    logic [2*PW-1:0] o_pixel_data;
    logic            o_pixel_data_valid;
    logic            i_ready;
    logic            o_last;
    logic            o_intr;

    out_line_buffer #(
        .PIXEL_WIDTH   (PW),
        .IN_LINE_WIDTH (W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_empty            (o_empty),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .i_ready            (i_ready),
        .o_last             (o_last),
        .o_intr             (o_intr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            last;
        logic [2*PW-1:0] data;
    } beat_t;

    beat_t sb[$];
    int total = 0, bad = 0;
    int beat_cnt = 0, intr_cnt = 0, cyc = 0;
    int seg_first = -1, seg_last = -1;
    logic            held_v = 1'b0;
    logic            held_last;
    logic [2*PW-1:0] held_data;

    // Pixel k (0 top0, 1 top1, 2 bot0, 3 bot1) of group g in line ln.
    function automatic logic [PW-1:0] pix(input int ln, input int g, input int k);
        return PW'((ln << 16) | (k << 8) | (g + 1));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input int ln);
        beat_t e;
        for (int g = 0; g < W; g++) begin
            e.last = (g == W - 1);
            e.data = {pix(ln, g, 1), pix(ln, g, 0)};
            sb.push_back(e);
        end
        for (int g = 0; g < W; g++) begin
            e.last = (g == W - 1);
            e.data = {pix(ln, g, 3), pix(ln, g, 2)};
            sb.push_back(e);
        end
    endtask

    task automatic write_line(input int ln, input bit push);
        for (int g = 0; g < W; g++) begin
            i_pixel_data       = {pix(ln, g, 3), pix(ln, g, 2), pix(ln, g, 1), pix(ln, g, 0)};
            i_pixel_data_valid = 1'b1;
            step();
        end
        i_pixel_data_valid = 1'b0;
        i_pixel_data       = '0;
        if (push) push_line(ln);
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((sb.size() != 0 || o_pixel_data_valid) && n < maxc) begin
            step();
            n++;
        end
        check("drain_done", 64'(sb.size()), 64'd0);
        repeat (3) step();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pops, stall stability and interrupt counting.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (o_intr) intr_cnt++;
            if (held_v) begin
                check("stall_valid", 64'(o_pixel_data_valid), 64'd1);
                check("stall_data", 64'(o_pixel_data), 64'(held_data));
                check("stall_last", 64'(o_last), 64'(held_last));
            end
            held_v = 1'b0;
            if (o_pixel_data_valid && !i_ready) begin
                held_v    = 1'b1;
                held_data = o_pixel_data;
                held_last = o_last;
            end
            if (o_pixel_data_valid && i_ready) begin
                beat_cnt++;
                if (seg_first < 0) seg_first = cyc;
                seg_last = cyc;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h expected no beat", o_pixel_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 64'(o_pixel_data), 64'(e.data));
                    check("beat_last", 64'(o_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, i0, n;
        rst                = 1'b1;
        i_pixel_data       = '0;
        i_pixel_data_valid = 1'b0;
        i_ready            = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_valid", 64'(o_pixel_data_valid), 64'd0);
        check("rst_data", 64'(o_pixel_data), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        check("rst_intr", 64'(o_intr), 64'd0);
        check("rst_empty", 64'(o_empty), 64'd1);
        step();
        check("idle_empty", 64'(o_empty), 64'd1);

        // Single line, first-beat latency and row ordering.
        b0 = beat_cnt; i0 = intr_cnt;
        write_line(0, 1'b1);
        step();
        check("lat_clk1", 64'(o_pixel_data_valid), 64'd0);
        step();
        check("lat_clk2", 64'(o_pixel_data_valid), 64'd0);
        step();
        check("lat_clk3", 64'(o_pixel_data_valid), 64'd1);
        check("first_beat", 64'(o_pixel_data), 64'h0000_0101_0000_01);
        wait_drain(100);
        check("l1_beats", 64'(beat_cnt - b0), 64'd8);
        check("l1_intr", 64'(intr_cnt - i0), 64'(IntrEn));

        // Two lines back-to-back, must stream without gaps.
        b0 = beat_cnt; i0 = intr_cnt; seg_first = -1;
        write_line(1, 1'b1);
        check("b2b_empty", 64'(o_empty), 64'd1);
        write_line(2, 1'b1);
        wait_drain(100);
        check("b2b_beats", 64'(beat_cnt - b0), 64'd16);
        check("b2b_span", 64'(seg_last - seg_first), 64'd15);
        check("b2b_intr", 64'(intr_cnt - i0), 64'(2 * IntrEn));

        // Ready toggling every clock.
        b0 = beat_cnt;
        write_line(3, 1'b1);
        for (int k = 0; k < 40; k++) begin
            i_ready = ~i_ready;
            step();
        end
        i_ready = 1'b1;
        wait_drain(100);
        check("tog_beats", 64'(beat_cnt - b0), 64'd8);

        // Both banks occupied with ready low; third line must be dropped.
        b0 = beat_cnt; i0 = intr_cnt;
        i_ready = 1'b0;
        write_line(4, 1'b1);
        check("full1_empty", 64'(o_empty), 64'd1);
        write_line(5, 1'b1);
        check("full2_empty", 64'(o_empty), 64'd0);
        write_line(6, 1'b0);
        check("drop_empty", 64'(o_empty), 64'd0);
        repeat (5) step();
        check("stalled_beats", 64'(beat_cnt - b0), 64'd0);
        i_ready = 1'b1;
        wait_drain(100);
        check("full_beats", 64'(beat_cnt - b0), 64'd16);
        check("full_intr", 64'(intr_cnt - i0), 64'(2 * IntrEn));

        // Reset after two beats discards the rest of the line.
        b0 = beat_cnt;
        write_line(7, 1'b1);
        n = 0;
        while (beat_cnt < b0 + 2 && n < 30) begin
            step();
            n++;
        end
        check("two_beats_seen", 64'(beat_cnt - b0), 64'd2);
        rst = 1'b1;
        step();
        check("mid_rst_valid", 64'(o_pixel_data_valid), 64'd0);
        check("mid_rst_data", 64'(o_pixel_data), 64'd0);
        check("mid_rst_last", 64'(o_last), 64'd0);
        check("mid_rst_intr", 64'(o_intr), 64'd0);
        check("mid_rst_empty", 64'(o_empty), 64'd1);
        rst = 1'b0;
        sb.delete();
        b0 = beat_cnt; i0 = intr_cnt;
        repeat (6) step();
        check("post_rst_quiet", 64'(beat_cnt - b0), 64'd0);
        write_line(8, 1'b1);
        wait_drain(100);
        check("post_rst_beats", 64'(beat_cnt - b0), 64'd8);
        check("post_rst_intr", 64'(intr_cnt - i0), 64'(IntrEn));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
